// File: rtl/poly_add_ctrl.sv
// Sequencer for the dual-lane polynomial adder: streams two source polynomials
// out of banked coefficient RAM through the adder and writes results to a destination bank.
module poly_add_ctrl #(
    parameter int N_WORDS = 256,
    parameter int IDX_W   = 8,
    parameter int BANK_W  = 2,
    parameter int ADD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BANK_W-1:0]       cfg_src1,
    input  logic [BANK_W-1:0]       cfg_src2,
    input  logic [BANK_W-1:0]       cfg_dst,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rd_en,
    output logic [BANK_W+IDX_W-1:0] rd_addr1,
    output logic [BANK_W+IDX_W-1:0] rd_addr2,
    input  logic [47:0]             rd_data1,
    input  logic [47:0]             rd_data2,
    output logic                    add_in_flag,
    output logic [47:0]             add_din1,
    output logic [47:0]             add_din2,
    input  logic [47:0]             add_dout,
    input  logic                    add_out_flag,
    output logic                    wr_en,
    output logic [BANK_W+IDX_W-1:0] wr_addr,
    output logic [47:0]             wr_data
);

    if (ADD_LAT < 0 || N_WORDS < 1 || (2 ** IDX_W) < N_WORDS) begin : g_bad_params
        $error("poly_add_ctrl: inconsistent N_WORDS/IDX_W/ADD_LAT");
    end

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_e            state_q, state_d;
    logic [BANK_W-1:0] src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic              wr_full_q, wr_full_d;
    logic              wr_started_q, wr_started_d;
    logic              in_flag_q;
    logic              err_q, err_d;
    logic              accept, last_wr, err_set;

    assign busy    = (state_q == READ) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign rd_en   = (state_q == READ);
    // wr_full_q stands in for wr_idx == N_WORDS so the index never needs to wrap
    assign wr_en   = add_out_flag && busy && !wr_full_q;
    assign last_wr = wr_en && (wr_idx_q == LAST_IDX);

    assign err_set = (add_out_flag && !busy)
                   || (add_out_flag && busy && wr_full_q)
                   || (!add_out_flag && busy && wr_started_q && !wr_full_q);

    always_comb begin
        state_d      = state_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        dst_d        = dst_q;
        rd_idx_d     = rd_idx_q;
        wr_idx_d     = wr_idx_q;
        wr_full_d    = wr_full_q;
        wr_started_d = wr_started_q;
        accept       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept       = 1'b1;
                    state_d      = READ;
                    src1_d       = cfg_src1;
                    src2_d       = cfg_src2;
                    dst_d        = cfg_dst;
                    rd_idx_d     = '0;
                    wr_idx_d     = '0;
                    wr_full_d    = 1'b0;
                    wr_started_d = 1'b0;
                end
            end
            READ: begin
                if (rd_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (last_wr || wr_full_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            wr_started_d = 1'b1;
            if (last_wr) begin
                wr_full_d = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        err_d = accept ? 1'b0 : (err_q || err_set);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            src1_q       <= '0;
            src2_q       <= '0;
            dst_q        <= '0;
            rd_idx_q     <= '0;
            wr_idx_q     <= '0;
            wr_full_q    <= 1'b0;
            wr_started_q <= 1'b0;
            in_flag_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            dst_q        <= dst_d;
            rd_idx_q     <= rd_idx_d;
            wr_idx_q     <= wr_idx_d;
            wr_full_q    <= wr_full_d;
            wr_started_q <= wr_started_d;
            in_flag_q    <= rd_en;
            err_q        <= err_d;
        end
    end

    assign err         = err_q;
    assign rd_addr1    = {src1_q, rd_idx_q};
    assign rd_addr2    = {src2_q, rd_idx_q};
    assign add_in_flag = in_flag_q;
    assign add_din1    = rd_data1;
    assign add_din2    = rd_data2;
    assign wr_addr     = {dst_q, wr_idx_q};
    assign wr_data     = add_dout;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Bench for poly_add_ctrl: banked RAM and modular adder environment, table of
// operations checked against a whole-memory model of the polynomial sum.
module tb_poly_add_ctrl;
    localparam int N   = 256;
    localparam int IW  = 8;
    localparam int BW  = 2;
    localparam int LAT = 2;
    localparam longint unsigned Q = 64'd16515073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cfg_src1 = '0, cfg_src2 = '0, cfg_dst = '0;
    logic        busy, done, err, rd_en, add_in_flag, wr_en, add_out_flag;
    logic [9:0]  rd_addr1, rd_addr2, wr_addr;
    logic [47:0] rd_data1, rd_data2, add_din1, add_din2, add_dout, wr_data;
    logic        inj = 1'b0;

    always #5 clk = ~clk;

    poly_add_ctrl #(.N_WORDS(N), .IDX_W(IW), .BANK_W(BW), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_src1(cfg_src1), .cfg_src2(cfg_src2), .cfg_dst(cfg_dst),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .add_in_flag(add_in_flag), .add_din1(add_din1), .add_din2(add_din2),
        .add_dout(add_dout), .add_out_flag(add_out_flag),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic logic [47:0] madd(input logic [47:0] a, input logic [47:0] b);
        longint unsigned hi, lo;
        hi = a[47:24];
        hi = (hi + b[47:24]) % Q;
        lo = a[23:0];
        lo = (lo + b[23:0]) % Q;
        return {hi[23:0], lo[23:0]};
    endfunction

    // Coefficient RAM: 4 banks, 1-cycle read, plus a bench-side load port
    logic [47:0] mem [4][N];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_idx = '0;
    logic [47:0] ld_w [4];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data1 <= mem[rd_addr1[9:8]][rd_addr1[7:0]];
            rd_data2 <= mem[rd_addr2[9:8]][rd_addr2[7:0]];
        end
        if (wr_en) mem[wr_addr[9:8]][wr_addr[7:0]] <= wr_data;
        if (ld_en) for (int b = 0; b < 4; b++) mem[b][ld_idx] <= ld_w[b];
    end

    // Two-stage modular adder
    logic [47:0] s1_d, s2_d;
    logic        s1_f, s2_f;
    always @(posedge clk) begin
        if (!rst) begin
            s1_f <= 1'b0;
            s2_f <= 1'b0;
        end else begin
            s1_f <= add_in_flag;
            s1_d <= madd(add_din1, add_din2);
            s2_f <= s1_f;
            s2_d <= s1_d;
        end
    end
    assign add_out_flag = s2_f | inj;
    assign add_dout     = s2_d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int src1, src2, dst, fill;
        int p1, p2, rst_cyc;
        int exp_done, exp_busy;
    } vec_t;

    vec_t        vecs [6];
    logic [47:0] img  [4][N];
    logic [47:0] expm [4][N];

    task automatic load_img();
        for (int i = 0; i < N; i++) begin
            ld_en  = 1'b1;
            ld_idx = 8'(i);
            for (int b = 0; b < 4; b++) ld_w[b] = img[b][i];
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int b = 0; b < 4; b++) img[b][i] = {24'($urandom % Q), 24'($urandom % Q)};
            case (mode)
                0: begin
                    img[0][i] = {24'(i), 24'(2 * i)};
                    img[1][i] = {24'd1000, 24'd5};
                end
                1: begin
                    img[0][i] = {24'd16515072, 24'd16515072};
                    img[1][i] = {24'd1, 24'd16515071};
                end
                2: img[1][i] = {24'(Q - 1), 24'(Q - 1)};
                default: ;
            endcase
        end
        load_img();
    endtask

    // Entered and left on a falling edge; start is raised immediately
    task automatic run_op(input vec_t v);
        int done_cyc = 0, busy_cnt = 0, rd_cnt = 0, in_cnt = 0, wr_cnt = 0;
        int in_first = -1, in_last = -1, addr_bad = 0, bad = 0;
        logic err_at_done = 1'b0;

        for (int b = 0; b < 4; b++)
            for (int i = 0; i < N; i++) expm[b][i] = img[b][i];
        for (int i = 0; i < N; i++) expm[v.dst][i] = madd(img[v.src1][i], img[v.src2][i]);

        start    = 1'b1;
        cfg_src1 = 2'(v.src1);
        cfg_src2 = 2'(v.src2);
        cfg_dst  = 2'(v.dst);
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= N + 50; k++) begin
            if (k == 1) chk("err_cleared_on_start", err, 0);
            if (v.rst_cyc != 0 && k == v.rst_cyc) begin
                rst = 1'b0;
                @(negedge clk);
                chk("abort_outputs_zero",
                    {busy, done, err, rd_en, add_in_flag, wr_en, rd_addr1, rd_addr2, wr_addr}, 0);
                rst = 1'b1;
                start = 1'b0;
                return;
            end
            busy_cnt += int'(busy);
            rd_cnt   += int'(rd_en);
            wr_cnt   += int'(wr_en);
            if (rd_en && int'(rd_addr1) != ((v.src1 << IW) | (k - 1))) addr_bad++;
            if (rd_en && int'(rd_addr2) != ((v.src2 << IW) | (k - 1))) addr_bad++;
            if (add_in_flag) begin
                if (in_first < 0) in_first = k;
                in_last = k;
                in_cnt++;
            end
            start = (k == v.p1 || k == v.p2);
            if (start) begin
                cfg_src1 = 2'(v.src1 ^ 3);
                cfg_src2 = 2'(v.src2 ^ 2);
                cfg_dst  = 2'(v.dst ^ 1);
            end
            if (done) begin
                done_cyc    = k;
                err_at_done = err;
                break;
            end
            @(negedge clk);
        end
        start    = 1'b1;
        cfg_src1 = 2'(v.src1 ^ 1);
        @(negedge clk);
        chk("start_in_done_ignored", {busy, done}, 0);
        start = 1'b0;

        chk("done_cycle", done_cyc, v.exp_done);
        chk("busy_cycles", busy_cnt, v.exp_busy);
        chk("rd_en_cycles", rd_cnt, N);
        chk("in_flag_first", in_first, 2);
        chk("in_flag_last", in_last, N + 1);
        chk("in_flag_count", in_cnt, N);
        chk("wr_count", wr_cnt, N);
        chk("rd_addr_bad", addr_bad, 0);
        chk("err_at_done", err_at_done, 0);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < N; i++)
                if (mem[b][i] != expm[b][i]) bad++;
        chk("mem_words_wrong", bad, 0);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < N; i++) img[b][i] = expm[b][i];
    endtask

    initial begin
        vec_t r;
        vecs[0] = '{0, 1, 2, 0, 0, 0,   0,   260, 259};
        vecs[1] = '{0, 1, 2, 1, 0, 0,   0,   260, 259};
        vecs[2] = '{0, 1, 0, 2, 0, 0,   0,   260, 259};
        vecs[3] = '{3, 2, 1, 3, 5, 100, 0,   260, 259};
        vecs[4] = '{1, 3, 3, 3, 0, 0,   130, 0,   0};
        vecs[5] = '{2, 0, 3, 3, 0, 0,   0,   260, 259};

        repeat (3) @(negedge clk);
        chk("reset_outputs_zero",
            {busy, done, err, rd_en, add_in_flag, wr_en, rd_addr1, rd_addr2, wr_addr}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, err, rd_en, wr_en}, 0);

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].fill);
            run_op(vecs[i]);
        end

        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("err_set_idle_flag", err, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        fill(3);
        run_op('{1, 2, 3, 3, 0, 0, 0, 260, 259});

        // Back-to-back random operations chained through the model image
        fill(3);
        for (int j = 0; j < 3; j++) begin
            r = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 3, 0, 0, 0, 260, 259};
            run_op(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
